simon_encrypt_core: RTL and testbench

SIMON_ENCRYPT_CORE -- requirements
Module: simon_encrypt_core

---
 rtl/simon_pkg.sv | 26 ++
 rtl/simon_round.sv | 27 ++
 rtl/simon_encrypt_core.sv | 106 ++++++++++
 tb/tb_simon_encrypt_core.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and rotate helpers for the SIMON 128/128 encryption core.
package simon_pkg;

  localparam int SIMON_WORD   = 64;
  localparam int SIMON_ROUNDS = 68;

  // SIMON z2 sequence, bit 0 is consumed in the first round.
  localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } simon_state_e;

  function automatic logic [SIMON_WORD-1:0] rotl(input logic [SIMON_WORD-1:0] v,
                                                 input int unsigned n);
    return (v << n) | (v >> (SIMON_WORD - n));
  endfunction

  function automatic logic [SIMON_WORD-1:0] rotr(input logic [SIMON_WORD-1:0] v,
                                                 input int unsigned n);
    return (v >> n) | (v << (SIMON_WORD - n));
  endfunction

endpackage

// File: rtl/simon_round.sv
// One SIMON 128/128 round plus one step of the two-word key schedule, purely combinational.
module simon_round
  import simon_pkg::*;
(
  input  logic [SIMON_WORD-1:0] x_i,
  input  logic [SIMON_WORD-1:0] y_i,
  input  logic [SIMON_WORD-1:0] k0_i,
  input  logic [SIMON_WORD-1:0] k1_i,
  input  logic                  zbit_i,
  output logic [SIMON_WORD-1:0] x_o,
  output logic [SIMON_WORD-1:0] y_o,
  output logic [SIMON_WORD-1:0] k_o
);

  logic [SIMON_WORD-1:0] f_x;
  logic [SIMON_WORD-1:0] t;

  always_comb begin
    f_x = (rotl(x_i, 1) & rotl(x_i, 8)) ^ rotl(x_i, 2);
    t   = rotr(k1_i, 3) ^ rotr(k1_i, 4);
    x_o = y_i ^ f_x ^ k0_i;
    y_o = x_i;
    // ~k0 ^ 3 is the SIMON round constant c = 2^64 - 4 folded into k0.
    k_o = ~k0_i ^ t ^ {{(SIMON_WORD-1){1'b0}}, zbit_i} ^ 64'h3;
  end

endmodule

// File: rtl/simon_encrypt_core.sv
// Iterative SIMON 128/128 encryptor: one round per clock, IDLE -> RUN -> DONE control.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds data stable while valid is high and ready is low.
module simon_encrypt_core
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS,
  parameter int WORD   = SIMON_WORD
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WORD-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WORD-1:0]  out_data,
  output logic               busy,
  output simon_state_e       dbg_state
);

  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  simon_state_e    state_q, state_d;
  logic [WORD-1:0] x_q, x_d, y_q, y_d;
  logic [WORD-1:0] k0_q, k0_d, k1_q, k1_d;
  logic [6:0]      rnd_q, rnd_d;
  logic [5:0]      zi_q, zi_d;

  logic [WORD-1:0] x_nx, y_nx, k_nx;

  simon_round u_round (
    .x_i    (x_q),
    .y_i    (y_q),
    .k0_i   (k0_q),
    .k1_i   (k1_q),
    .zbit_i (Z2[zi_q]),
    .x_o    (x_nx),
    .y_o    (y_nx),
    .k_o    (k_nx)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    rnd_d   = rnd_q;
    zi_d    = zi_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          k1_d    = in_data[255:192];
          k0_d    = in_data[191:128];
          x_d     = in_data[127:64];
          y_d     = in_data[63:0];
          rnd_d   = '0;
          zi_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d  = x_nx;
        y_d  = y_nx;
        k0_d = k1_q;
        k1_d = k_nx;
        zi_d = (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
        // The round counter parks on the last index instead of wrapping.
        if (rnd_q == LAST_RND) state_d = DONE;
        else                   rnd_d   = rnd_q + 7'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      rnd_q   <= '0;
      zi_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      rnd_q   <= rnd_d;
      zi_q    <= zi_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_data  = {x_q, y_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_simon_encrypt_core.sv
// Self-checking bench for simon_encrypt_core: reference SIMON model, per-cycle protocol checker, directed tests.
module tb_simon_encrypt_core;

  localparam int ROUNDS = 68;
  localparam logic [255:0] KAT_IN = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100,
                                     64'h6373656420737265, 64'h6c6c657661727420};
  localparam logic [127:0] KAT_CT = {64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc};

  logic         clk_100MHz = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  simon_pkg::simon_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  simon_encrypt_core dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  string z2_str = "10101111011100000011010010011000101000010001111110010110110011";

  function automatic logic [63:0] m_rotl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [255:0] blk);
    logic [63:0] rk [ROUNDS];
    logic [63:0] x, y, tmp;
    logic [63:0] zb;
    rk[0] = blk[191:128];
    rk[1] = blk[255:192];
    for (int i = 0; i < ROUNDS - 2; i++) begin
      tmp = m_rotr(rk[i+1], 3);
      tmp = tmp ^ m_rotr(tmp, 1);
      zb  = (z2_str[i % 62] == 8'h31) ? 64'd1 : 64'd0;
      rk[i+2] = ~rk[i] ^ tmp ^ zb ^ 64'h3;
    end
    x = blk[127:64];
    y = blk[63:0];
    for (int i = 0; i < ROUNDS; i++) begin
      tmp = x;
      x   = y ^ ((m_rotl(x, 1) & m_rotl(x, 8)) ^ m_rotl(x, 2)) ^ rk[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no response expected a handshake", name);
  endtask

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [127:0] exp_q[$];
  int m_phase = 0;  // 0: accepting, 1: computing, 2: result presented
  int m_cnt   = 0;

  always @(negedge clk_100MHz) begin
    if (!reset_n) begin
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_vec("rst_out_data", out_data, 128'd0);
      check_int("rst_state", int'(dbg_state), int'(simon_pkg::IDLE));
      exp_q.delete();
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      check_bit("cyc_in_ready", in_ready, m_phase == 0);
      check_bit("cyc_busy", busy, m_phase == 1);
      check_bit("cyc_out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        if (exp_q.size() == 0) note_fail("cyc_exp_q_empty");
        else                   check_vec("cyc_out_data", out_data, exp_q[0]);
      end
      case (m_phase)
        0: if (in_valid) begin
             exp_q.push_back(ref_encrypt(in_data));
             m_phase = 1;
             m_cnt   = 0;
           end
        1: begin
             m_cnt++;
             if (m_cnt == ROUNDS) m_phase = 2;
           end
        default: if (out_ready) begin
             if (exp_q.size() != 0) void'(exp_q.pop_front());
             m_phase = 0;
           end
      endcase
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_block(input logic [255:0] blk, output int acc_cyc);
    int waited = 0;
    acc_cyc  = -1;
    in_data  = blk;
    in_valid = 1'b1;
    forever begin
      @(negedge clk_100MHz);
      if (in_ready) break;
      waited++;
      if (waited > 300) begin
        note_fail("send_timeout");
        break;
      end
    end
    @(posedge clk_100MHz);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int start, output logic [127:0] data,
                             output int lat, output int done_cyc);
    lat      = start;
    data     = '0;
    done_cyc = -1;
    forever begin
      @(negedge clk_100MHz);
      if (out_valid) begin
        data     = out_data;
        done_cyc = cyc;
        break;
      end
      if (lat > 200) begin
        note_fail("result_timeout");
        break;
      end
      @(posedge clk_100MHz);
      lat++;
    end
    @(posedge clk_100MHz);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] d1, d2;
  logic [255:0] blk, blk2;
  int lat, l2, acc1, acc2, done1, done2;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Model pinned to the published SIMON 128/128 vector.
    check_vec("model_kat", ref_encrypt(KAT_IN), KAT_CT);

    repeat (3) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    @(posedge clk_100MHz);
    #1;

    // Known answer with exact latency.
    send_block(KAT_IN, acc1);
    wait_result(0, d1, lat, done1);
    check_vec("kat_data", d1, KAT_CT);
    check_int("kat_latency", lat, 68);

    // Backpressure: result held for 20 cycles.
    out_ready = 1'b0;
    send_block(KAT_IN, acc1);
    wait_result(0, d1, lat, done1);
    check_vec("bp_data_first", d1, KAT_CT);
    repeat (20) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check_bit("bp_out_valid", out_valid, 1'b1);
    check_bit("bp_in_ready", in_ready, 1'b0);
    check_vec("bp_data_held", out_data, KAT_CT);
    @(posedge clk_100MHz);
    #1;
    out_ready = 1'b1;
    @(posedge clk_100MHz);
    #1;
    check_bit("bp_release_in_ready", in_ready, 1'b1);
    check_bit("bp_release_out_valid", out_valid, 1'b0);

    // in_valid pulse with other data during RUN is ignored.
    send_block(KAT_IN, acc1);
    repeat (29) @(posedge clk_100MHz);
    #1;
    in_data  = {8{32'hdeadbeef}};
    in_valid = 1'b1;
    @(posedge clk_100MHz);
    #1;
    in_valid = 1'b0;
    wait_result(30, d1, lat, done1);
    check_vec("run_pulse_data", d1, KAT_CT);
    check_int("run_pulse_latency", lat, 68);

    // Asynchronous reset in the middle of a block.
    send_block(KAT_IN, acc1);
    repeat (40) @(posedge clk_100MHz);
    #3;
    reset_n = 1'b0;
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check_vec("midrst_out_data", out_data, 128'd0);
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    repeat (80) @(posedge clk_100MHz);
    #1;
    send_block(KAT_IN, acc1);
    wait_result(0, d1, lat, done1);
    check_vec("post_rst_data", d1, KAT_CT);
    check_int("post_rst_latency", lat, 68);

    // Back-to-back blocks with in_valid held high.
    blk2 = {64'h0011223344556677, 64'h8899aabbccddeeff, 64'h0123456789abcdef, 64'hfedcba9876543210};
    fork
      begin
        send_block(KAT_IN, acc1);
        send_block(blk2, acc2);
      end
      begin
        wait_result(0, d1, lat, done1);
        wait_result(0, d2, l2, done2);
      end
    join
    check_vec("b2b_first", d1, KAT_CT);
    check_vec("b2b_second", d2, ref_encrypt(blk2));
    check_bit("b2b_gap", (acc2 - done1) >= 2, 1'b1);

    // Random key/plaintext pairs.
    for (int n = 0; n < 500; n++) begin
      for (int j = 0; j < 8; j++) blk[32*j +: 32] = $urandom_range(32'hffff_ffff, 0);
      send_block(blk, acc1);
      wait_result(0, d1, lat, done1);
      check_vec("rand_data", d1, ref_encrypt(blk));
      check_int("rand_latency", lat, 68);
    end

    repeat (3) @(posedge clk_100MHz);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
